// File: rtl/cam_match_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : cam_match_sequencer_if
// Purpose  : Bundles the CAM status handshake, the match index handshake and
//            the status/statistics outputs of cam_match_sequencer.
// Ports    : (interface signals)
//   status_in    [N_ENTRIES]  CAM match vector, bit i = entry i matched
//   status_valid              status_in valid
//   status_ready              sequencer can accept a vector
//   flush                     synchronous abort of the current search
//   match_idx    [IDX_W]      index of current matching entry
//   match_valid               match_idx valid
//   match_ready               consumer accepts match_idx
//   match_last                current index is final match of this search
//   hit_count    [IDX_W+1]    popcount of last captured vector
//   miss                      one-cycle pulse for an all-zero vector
//   total_hits   [CNT_W]      saturating count of delivered indices
// Modports : master = CAM/consumer side, slave = sequencer side
// Revision : 1.0 - initial release
// ============================================================================
interface cam_match_sequencer_if #(
  parameter int N_ENTRIES = 8,
  parameter int IDX_W     = 3,
  parameter int CNT_W     = 16
);
  logic [N_ENTRIES-1:0] status_in;
  logic                 status_valid;
  logic                 status_ready;
  logic                 flush;
  logic [IDX_W-1:0]     match_idx;
  logic                 match_valid;
  logic                 match_ready;
  logic                 match_last;
  logic [IDX_W:0]       hit_count;
  logic                 miss;
  logic [CNT_W-1:0]     total_hits;

  modport master (
    output status_in, status_valid, flush, match_ready,
    input  status_ready, match_idx, match_valid, match_last,
           hit_count, miss, total_hits
  );

  modport slave (
    input  status_in, status_valid, flush, match_ready,
    output status_ready, match_idx, match_valid, match_last,
           hit_count, miss, total_hits
  );
endinterface
`default_nettype wire

// File: rtl/cam_match_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cam_match_sequencer
// Purpose  : Captures a CAM match vector and streams out the indices of all
//            matching entries, lowest first, with hit count, miss pulse and a
//            saturating lifetime hit counter.
// Ports    :
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of cam_match_sequencer_if (see interface header)
// Revision : 1.0 - initial release
// ============================================================================
module cam_match_sequencer #(
  parameter int N_ENTRIES = 8,
  parameter int IDX_W     = 3,
  parameter int CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cam_match_sequencer_if.slave  bus
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  state_t               r_state;
  logic [N_ENTRIES-1:0] r_pend;
  logic [IDX_W-1:0]     r_match_idx;
  logic                 r_match_valid;
  logic                 r_match_last;
  logic                 r_status_ready;
  logic [IDX_W:0]       r_hit_count;
  logic                 r_miss;
  logic [CNT_W-1:0]     r_total_hits;

  logic                 w_accept;
  logic                 w_xfer;
  logic [N_ENTRIES-1:0] w_pend_nxt;

  // Index of the lowest set bit; 0 for an empty vector.
  function automatic logic [IDX_W-1:0] f_lowest(input logic [N_ENTRIES-1:0] v);
    f_lowest = '0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (v[i]) f_lowest = IDX_W'(i);
    end
  endfunction

  function automatic logic [IDX_W:0] f_popcount(input logic [N_ENTRIES-1:0] v);
    f_popcount = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (v[i]) f_popcount = f_popcount + (IDX_W+1)'(1);
    end
  endfunction

  // Exactly one bit set: non-zero and clearing the lowest bit leaves nothing.
  function automatic logic f_single(input logic [N_ENTRIES-1:0] v);
    f_single = (v != '0) && ((v & (v - N_ENTRIES'(1))) == '0);
  endfunction

  assign w_accept = (r_state == S_IDLE) && bus.status_valid;
  assign w_xfer   = (r_state == S_EMIT) && bus.match_ready;

  // Next pending set. Clearing the lowest set bit (v & (v-1)) removes exactly
  // the index currently presented on match_idx.
  always_comb begin
    w_pend_nxt = r_pend;
    if (bus.flush) begin
      w_pend_nxt = '0;
    end else if (w_accept) begin
      w_pend_nxt = bus.status_in;
    end else if (w_xfer) begin
      w_pend_nxt = r_pend & (r_pend - N_ENTRIES'(1));
    end
  end

  // All outputs are registered; match_idx/match_last are precomputed from the
  // next pending set so they are valid in the same cycle as match_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_pend         <= '0;
      r_match_idx    <= '0;
      r_match_valid  <= 1'b0;
      r_match_last   <= 1'b0;
      r_status_ready <= 1'b1;
      r_hit_count    <= '0;
      r_miss         <= 1'b0;
      r_total_hits   <= '0;
    end else begin
      r_miss <= 1'b0;
      r_pend <= w_pend_nxt;
      if (bus.flush) begin
        // Flush wins over capture and transfer; statistics are preserved.
        r_state        <= S_IDLE;
        r_match_valid  <= 1'b0;
        r_match_last   <= 1'b0;
        r_match_idx    <= '0;
        r_status_ready <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.status_valid) begin
              r_hit_count <= f_popcount(bus.status_in);
              if (bus.status_in == '0) begin
                r_miss <= 1'b1;
              end else begin
                r_state        <= S_EMIT;
                r_match_valid  <= 1'b1;
                r_status_ready <= 1'b0;
                r_match_idx    <= f_lowest(bus.status_in);
                r_match_last   <= f_single(bus.status_in);
              end
            end
          end
          S_EMIT: begin
            // Without match_ready nothing is updated, so a stall holds outputs.
            if (bus.match_ready) begin
              if (r_total_hits != '1) begin
                r_total_hits <= r_total_hits + CNT_W'(1);
              end
              if (r_match_last) begin
                r_state        <= S_IDLE;
                r_match_valid  <= 1'b0;
                r_match_last   <= 1'b0;
                r_match_idx    <= '0;
                r_status_ready <= 1'b1;
              end else begin
                r_match_idx  <= f_lowest(w_pend_nxt);
                r_match_last <= f_single(w_pend_nxt);
              end
            end
          end
          default: begin
            r_state        <= S_IDLE;
            r_match_valid  <= 1'b0;
            r_match_last   <= 1'b0;
            r_status_ready <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.status_ready = r_status_ready;
  assign bus.match_idx    = r_match_idx;
  assign bus.match_valid  = r_match_valid;
  assign bus.match_last   = r_match_last;
  assign bus.hit_count    = r_hit_count;
  assign bus.miss         = r_miss;
  assign bus.total_hits   = r_total_hits;

endmodule
`default_nettype wire

// File: tb/tb_cam_match_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cam_match_sequencer
// Purpose  : Self-checking bench for cam_match_sequencer; expected indices are
//            derived from the vector's set bits in a queue, totals by a
//            saturating integer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cam_match_sequencer;
  localparam int N  = 8;
  localparam int IW = 3;
  localparam int CW = 16;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cam_match_sequencer_if #(.N_ENTRIES(N), .IDX_W(IW), .CNT_W(CW)) bus ();

  cam_match_sequencer #(.N_ENTRIES(N), .IDX_W(IW), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int m_total  = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat_add(input int a, input int b);
    return (a + b > SAT) ? SAT : a + b;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus.status_in = '0; bus.status_valid = 1'b0; bus.flush = 1'b0; bus.match_ready = 1'b0;
    repeat (2) step();
    @(negedge clk); rst_n = 1'b1;
    step();
    n_checks++; if (bus.status_ready !== 1'b1) $display("FAIL reset_ready: got %b exp 1", bus.status_ready); else n_pass++;
    n_checks++; if ({bus.match_valid, bus.match_idx, bus.match_last} !== 5'b0) $display("FAIL reset_match: got %b exp 0", {bus.match_valid, bus.match_idx, bus.match_last}); else n_pass++;
    n_checks++; if ({bus.hit_count, bus.miss, bus.total_hits} !== 21'b0) $display("FAIL reset_stats: got %h exp 0", {bus.hit_count, bus.miss, bus.total_hits}); else n_pass++;
  endtask

  task automatic test_single();
    bus.status_in = 8'h20; bus.status_valid = 1'b1; bus.match_ready = 1'b1;
    step();
    bus.status_valid = 1'b0;
    n_checks++; if ({bus.match_valid, bus.match_idx, bus.match_last} !== {1'b1, 3'd5, 1'b1}) $display("FAIL single_out: got v%b i%0d l%b exp v1 i5 l1", bus.match_valid, bus.match_idx, bus.match_last); else n_pass++;
    n_checks++; if (bus.hit_count !== 4'd1) $display("FAIL single_hit: got %0d exp 1", bus.hit_count); else n_pass++;
    step();
    m_total = sat_add(m_total, 1);
    n_checks++; if ({bus.match_valid, bus.status_ready} !== 2'b01) $display("FAIL single_idle: got v%b r%b exp v0 r1", bus.match_valid, bus.status_ready); else n_pass++;
    n_checks++; if (int'(bus.total_hits) !== m_total) $display("FAIL single_total: got %0d exp %0d", bus.total_hits, m_total); else n_pass++;
    bus.match_ready = 1'b0;
  endtask

  task automatic test_multi_stall();
    int q[$];
    logic [7:0] vec = 8'hA5;
    for (int i = 0; i < N; i++) if (vec[i]) q.push_back(i);
    bus.status_in = vec; bus.status_valid = 1'b1; bus.match_ready = 1'b0;
    step();
    bus.status_valid = 1'b0;
    n_checks++; if (int'(bus.hit_count) !== q.size()) $display("FAIL multi_hit: got %0d exp %0d", bus.hit_count, q.size()); else n_pass++;
    while (q.size() > 0) begin
      n_checks++; if ({bus.match_valid, bus.match_idx, bus.match_last} !== {1'b1, 3'(q[0]), q.size() == 1}) $display("FAIL multi_idx: got v%b i%0d l%b exp i%0d", bus.match_valid, bus.match_idx, bus.match_last, q[0]); else n_pass++;
      bus.match_ready = 1'b0;
      step();
      n_checks++; if ({bus.match_valid, bus.match_idx, bus.match_last} !== {1'b1, 3'(q[0]), q.size() == 1}) $display("FAIL multi_stall: got v%b i%0d l%b exp i%0d", bus.match_valid, bus.match_idx, bus.match_last, q[0]); else n_pass++;
      bus.match_ready = 1'b1;
      step();
      void'(q.pop_front());
      m_total = sat_add(m_total, 1);
    end
    bus.match_ready = 1'b0;
    n_checks++; if ({bus.match_valid, bus.status_ready} !== 2'b01) $display("FAIL multi_idle: got v%b r%b exp v0 r1", bus.match_valid, bus.status_ready); else n_pass++;
    n_checks++; if (int'(bus.total_hits) !== m_total) $display("FAIL multi_total: got %0d exp %0d", bus.total_hits, m_total); else n_pass++;
  endtask

  task automatic test_miss_stream();
    bus.status_in = 8'h00; bus.status_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++; if ({bus.miss, bus.match_valid, bus.status_ready} !== 3'b101) $display("FAIL miss_pulse%0d: got m%b v%b r%b exp m1 v0 r1", k, bus.miss, bus.match_valid, bus.status_ready); else n_pass++;
    end
    bus.status_valid = 1'b0;
    step();
    n_checks++; if (bus.miss !== 1'b0) $display("FAIL miss_end: got %b exp 0", bus.miss); else n_pass++;
    n_checks++; if ({bus.hit_count, bus.total_hits} !== {4'd0, CW'(m_total)}) $display("FAIL miss_stats: got h%0d t%0d exp h0 t%0d", bus.hit_count, bus.total_hits, m_total); else n_pass++;
  endtask

  task automatic test_flush();
    bus.status_in = 8'hFF; bus.status_valid = 1'b1; bus.match_ready = 1'b1;
    step();
    bus.status_valid = 1'b0;
    step(); step();
    m_total = sat_add(m_total, 2);
    n_checks++; if (bus.match_idx !== 3'd2) $display("FAIL flush_pre: got %0d exp 2", bus.match_idx); else n_pass++;
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    n_checks++; if ({bus.match_valid, bus.status_ready, bus.miss} !== 3'b010) $display("FAIL flush_idle: got v%b r%b m%b exp v0 r1 m0", bus.match_valid, bus.status_ready, bus.miss); else n_pass++;
    n_checks++; if (int'(bus.total_hits) !== m_total) $display("FAIL flush_total: got %0d exp %0d", bus.total_hits, m_total); else n_pass++;
    n_checks++; if (bus.hit_count !== 4'd8) $display("FAIL flush_hit: got %0d exp 8", bus.hit_count); else n_pass++;
    bus.status_in = 8'h01; bus.status_valid = 1'b1;
    step();
    bus.status_valid = 1'b0;
    n_checks++; if ({bus.match_valid, bus.match_idx, bus.match_last} !== {1'b1, 3'd0, 1'b1}) $display("FAIL flush_next: got v%b i%0d l%b exp v1 i0 l1", bus.match_valid, bus.match_idx, bus.match_last); else n_pass++;
    step();
    m_total = sat_add(m_total, 1);
    bus.match_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    bus.status_in = 8'h80; bus.status_valid = 1'b1; bus.match_ready = 1'b1;
    step();
    // Next vector is presented while busy and must wait.
    bus.status_in = 8'h03;
    n_checks++; if ({bus.status_ready, bus.match_idx, bus.match_last} !== {1'b0, 3'd7, 1'b1}) $display("FAIL b2b_first: got r%b i%0d l%b exp r0 i7 l1", bus.status_ready, bus.match_idx, bus.match_last); else n_pass++;
    step();
    m_total = sat_add(m_total, 1);
    n_checks++; if ({bus.status_ready, bus.hit_count} !== {1'b1, 4'd1}) $display("FAIL b2b_ignored: got r%b h%0d exp r1 h1", bus.status_ready, bus.hit_count); else n_pass++;
    step();
    bus.status_valid = 1'b0;
    n_checks++; if ({bus.match_idx, bus.match_last, bus.hit_count} !== {3'd0, 1'b0, 4'd2}) $display("FAIL b2b_second: got i%0d l%b h%0d exp i0 l0 h2", bus.match_idx, bus.match_last, bus.hit_count); else n_pass++;
    step(); step();
    m_total = sat_add(m_total, 2);
    bus.match_ready = 1'b0;
    n_checks++; if (int'(bus.total_hits) !== m_total) $display("FAIL b2b_total: got %0d exp %0d", bus.total_hits, m_total); else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] vec;
    int q[$];
    int guard;
    bit rdy;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0:       vec = 8'h00;
        1:       vec = 8'hFF;
        default: vec = 8'($urandom);
      endcase
      q.delete();
      for (int i = 0; i < N; i++) if (vec[i]) q.push_back(i);
      bus.status_in = vec; bus.status_valid = 1'b1; bus.match_ready = 1'b0;
      step();
      bus.status_valid = 1'b0; bus.status_in = 8'($urandom);
      n_checks++; if (int'(bus.hit_count) !== q.size()) $display("FAIL rnd_hit: vec %h got %0d exp %0d", vec, bus.hit_count, q.size()); else n_pass++;
      if (q.size() == 0) begin
        n_checks++; if ({bus.miss, bus.match_valid} !== 2'b10) $display("FAIL rnd_miss: got m%b v%b exp m1 v0", bus.miss, bus.match_valid); else n_pass++;
      end
      guard = 0;
      while (q.size() > 0 && guard < 200) begin
        n_checks++; if ({bus.match_valid, bus.match_idx, bus.match_last} !== {1'b1, 3'(q[0]), q.size() == 1}) $display("FAIL rnd_idx: vec %h got v%b i%0d l%b exp i%0d", vec, bus.match_valid, bus.match_idx, bus.match_last, q[0]); else n_pass++;
        rdy = 1'($urandom_range(0, 1));
        bus.match_ready = rdy;
        step();
        guard++;
        if (rdy) begin
          void'(q.pop_front());
          m_total = sat_add(m_total, 1);
        end
      end
      bus.match_ready = 1'b0;
      if (guard >= 200) begin
        n_checks++; $display("FAIL rnd_timeout: vec %h got no completion exp completion", vec);
      end
      n_checks++; if ({bus.match_valid, bus.status_ready} !== 2'b01) $display("FAIL rnd_idle: got v%b r%b exp v0 r1", bus.match_valid, bus.status_ready); else n_pass++;
      n_checks++; if (int'(bus.total_hits) !== m_total) $display("FAIL rnd_total: got %0d exp %0d", bus.total_hits, m_total); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_emit();
    bus.status_in = 8'h0C; bus.status_valid = 1'b1; bus.match_ready = 1'b1;
    step();
    bus.status_valid = 1'b0;
    step();
    n_checks++; if ({bus.match_valid, bus.match_idx} !== {1'b1, 3'd3}) $display("FAIL rstmid_pre: got v%b i%0d exp v1 i3", bus.match_valid, bus.match_idx); else n_pass++;
    bus.match_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({bus.match_valid, bus.match_idx, bus.match_last, bus.hit_count, bus.miss, bus.total_hits} !== 26'b0) $display("FAIL rstmid_async: got %h exp 0", {bus.match_valid, bus.match_idx, bus.match_last, bus.hit_count, bus.miss, bus.total_hits}); else n_pass++;
    m_total = 0;
    @(negedge clk); rst_n = 1'b1;
    step();
    n_checks++; if ({bus.status_ready, bus.match_valid, bus.total_hits} !== {1'b1, 1'b0, CW'(0)}) $display("FAIL rstmid_release: got r%b v%b t%0d exp r1 v0 t0", bus.status_ready, bus.match_valid, bus.total_hits); else n_pass++;
  endtask

  task automatic test_saturation();
    bus.match_ready = 1'b1;
    for (int v = 0; v < 8193; v++) begin
      bus.status_in = 8'hFF; bus.status_valid = 1'b1;
      step();
      bus.status_valid = 1'b0;
      repeat (8) step();
      m_total = sat_add(m_total, 8);
      if (v == 8191 || v == 8192) begin
        n_checks++; if (int'(bus.total_hits) !== m_total) $display("FAIL sat_total%0d: got %0d exp %0d", v, bus.total_hits, m_total); else n_pass++;
      end
    end
    bus.match_ready = 1'b0;
    n_checks++; if (bus.total_hits !== 16'hFFFF) $display("FAIL sat_final: got %h exp ffff", bus.total_hits); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi_stall();
    test_miss_stream();
    test_flush();
    test_back_to_back();
    test_random();
    test_reset_mid_emit();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
